reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning address width; depth = 2**ADDR_W (8 entries).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port write_enabled  input  1  write strobe for the current cycle.
REQ-006 SHALL have port ra1  input  ADDR_W  read address, port 1.
REQ-007 SHALL have port ra2  input  ADDR_W  read address, port 2.
REQ-008 SHALL have port wa  input  ADDR_W  write address.
REQ-009 SHALL have port wd  input  DATA_W  write data.
REQ-010 SHALL have port rd1  output  DATA_W  read data, port 1.
REQ-011 SHALL have port rd2  output  DATA_W  read data, port 2.
REQ-012 SHALL use one clock; reset synchronous and active-high, as already decided.

Function
REQ-013 SHALL store 2**ADDR_W words of DATA_W bits; every entry, including address 0, is writable (no hardwired-zero register).
REQ-014 SHALL write wd into entry wa on a rising clk edge when write_enabled=1 and rst=0.
REQ-015 SHALL leave all entries unchanged on any edge with write_enabled=0.
REQ-016 SHALL drive rd1 = entry[ra1] and rd2 = entry[ra2] combinationally (zero-cycle read latency); changing ra1/ra2 updates outputs within the same cycle.
REQ-017 SHALL allow ra1 and ra2 to address the same or different entries simultaneously with independent, correct results.
REQ-018 SHALL, without bypass, return the old contents on a read of wa during a write cycle; the new value appears after the edge.
REQ-019 SHALL never produce X on rd1/rd2 after reset, since all addresses are in range.
REQ-020 SHALL give rst priority over write_enabled when both are asserted on the same edge (entry stays zero).

Reset
REQ-021 SHALL clear every entry to 0 on a rising clk edge with rst=1; rd1/rd2 therefore read 0 for all addresses after reset.
REQ-022 SHALL ignore write_enabled, wa, wd for the duration of rst=1.
REQ-023 SHALL have no asynchronous reset path; contents before the first reset edge are undefined.

Configuration
REQ-024 SHALL support macro REG_FILE_BYPASS_EN: when defined, if write_enabled=1 and rst=0 and raN==wa, rdN SHALL equal wd combinationally in that same cycle (write-to-read forwarding, per port).
REQ-025 SHALL, when REG_FILE_BYPASS_EN is undefined, contain no forwarding logic and follow REQ-018.

Structure
REQ-026 SHALL place DATA_W/ADDR_W defaults and the reset value constant (all zeros) in shared package reg_file_pkg.
REQ-027 SHALL implement each read port as instances of one sub-module reg_file_rd_port (address decode/mux plus optional bypass), instantiated twice.

Verification
REQ-028 SHALL cover: rst=1 for one edge, then ra1=0..7 swept -> rd1=0x00000000 for every address.
REQ-029 SHALL cover: write_enabled=1, wa=0, wd=0x000000FF for one edge, then write_enabled=0, ra2=0 -> rd2=0x000000FF; entry 0 unchanged on later edges.
REQ-030 SHALL cover: write entry k with 0xA5A50000+k for k=0..7, read ra1=k, ra2=7-k -> rd1=0xA5A50000+k, rd2=0xA5A50000+(7-k).
REQ-031 SHALL cover: write_enabled=0, wa=3, wd=0xDEADBEEF, one edge -> entry 3 retains its prior value.
REQ-032 SHALL cover: entry 5=0x11111111, write_enabled=1, wa=5, wd=0x22222222, ra1=5 before edge -> rd1=0x11111111 without REG_FILE_BYPASS_EN, 0x22222222 with it; both 0x22222222 after edge.
REQ-033 SHALL cover: rst=1 and write_enabled=1, wa=2, wd=0xFFFFFFFF on same edge -> rd1 at ra1=2 reads 0x00000000.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and reset constant for the reg_file register array.
// Included by reg_file and reg_file_rd_port; REG_FILE_BYPASS_EN has no effect here.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  localparam logic [DEF_DATA_W-1:0] RESET_VALUE = '0;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port: selects an entry by address.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [DATA_W-1:0] entries [2**ADDR_W],
  input  logic [ADDR_W-1:0] ra,
`ifdef REG_FILE_BYPASS_EN
  input  logic              fwd_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
`endif
  output logic [DATA_W-1:0] rd
);

`ifdef REG_FILE_BYPASS_EN
  assign rd = (fwd_en && (ra == wa)) ? wd : entries[ra];
`else
  assign rd = entries[ra];
`endif

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// Two-read/one-write register array with synchronous active-high clear.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enabled,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] entries [DEPTH];

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '{default: DATA_W'(RESET_VALUE)};
    end else if (write_enabled) begin
      entries[wa] <= wd;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = write_enabled & ~rst;
`endif

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .entries (entries),
    .ra      (ra1),
`ifdef REG_FILE_BYPASS_EN
    .fwd_en  (fwd_en),
    .wa      (wa),
    .wd      (wd),
`endif
    .rd      (rd1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .entries (entries),
    .ra      (ra2),
`ifdef REG_FILE_BYPASS_EN
    .fwd_en  (fwd_en),
    .wa      (wa),
    .wd      (wd),
`endif
    .rd      (rd2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus random traffic vs an array model.
// Expectations follow REG_FILE_BYPASS_EN when it is defined for the build.
module tb_reg_file;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enabled;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd, rd1, rd2;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_enabled (write_enabled),
    .ra1           (ra1),
    .ra2           (ra2),
    .wa            (wa),
    .wd            (wd),
    .rd1           (rd1),
    .rd2           (rd2)
  );

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    bit            chk;
    string         name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic we, input int a1, input int a2,
                     input int w, input logic [DW-1:0] d,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                     input bit chk, input string name);
    vec_t v;
    v.rst = r; v.we = we;
    v.ra1 = AW'(a1); v.ra2 = AW'(a2); v.wa = AW'(w); v.wd = d;
    v.e1 = e1; v.e2 = e2; v.chk = chk; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, compare 2 ns later, the rising edge then commits.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; write_enabled = v.we;
    ra1 = v.ra1; ra2 = v.ra2; wa = v.wa; wd = v.wd;
    #2;
    if (v.chk) begin
      n_vec++;
      if (rd1 !== v.e1) begin
        n_bad++;
        $display("FAIL %s rd1 ra1=%0d got %h want %h", v.name, v.ra1, rd1, v.e1);
      end
      n_vec++;
      if (rd2 !== v.e2) begin
        n_bad++;
        $display("FAIL %s rd2 ra2=%0d got %h want %h", v.name, v.ra2, rd2, v.e2);
      end
    end
  endtask

  logic [DW-1:0] model [DEPTH];

  initial begin
    logic [DW-1:0] old_k, old_mk, e1, e2;
    vec_t v;

    rst = 1'b0; write_enabled = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;

    // reset coincident with a write; contents before it are undefined
    add(1, 1, 2, 0, 2, 32'hFFFF_FFFF, 0, 0, 0, "rst_with_we");
    for (int a = 0; a < DEPTH; a++)
      add(0, 0, a, 7 - a, 0, 0, 32'h0, 32'h0, 1, "reset_sweep");

    add(0, 1, 1, 0, 0, 32'h0000_00FF, 32'h0, BYP ? 32'h0000_00FF : 32'h0, 1, "wr0_same_cycle");
    add(0, 0, 0, 0, 0, 32'h0000_0123, 32'h0000_00FF, 32'h0000_00FF, 1, "rd0_after");
    add(0, 0, 0, 0, 0, 32'h0000_0456, 32'h0000_00FF, 32'h0000_00FF, 1, "rd0_hold");
    add(0, 0, 1, 0, 0, 32'h0,         32'h0,         32'h0000_00FF, 1, "rd0_hold2");

    for (int k = 0; k < DEPTH; k++) begin
      old_k  = (k == 0) ? 32'h0000_00FF : 32'h0;
      old_mk = (7 - k < k) ? 32'hA5A5_0000 + DW'(7 - k) : 32'h0;
      e1 = BYP ? 32'hA5A5_0000 + DW'(k) : old_k;
      add(0, 1, k, 7 - k, k, 32'hA5A5_0000 + DW'(k), e1, old_mk, 1, "pattern_wr");
    end
    for (int k = 0; k < DEPTH; k++)
      add(0, 0, k, 7 - k, 0, 0, 32'hA5A5_0000 + DW'(k),
          32'hA5A5_0000 + DW'(7 - k), 1, "pattern_rd");

    add(0, 0, 3, 3, 3, 32'hDEAD_BEEF, 32'hA5A5_0003, 32'hA5A5_0003, 1, "we0_ignored");
    add(0, 0, 3, 4, 0, 32'h0,         32'hA5A5_0003, 32'hA5A5_0004, 1, "we0_retained");

    add(0, 1, 5, 0, 5, 32'h1111_1111, BYP ? 32'h1111_1111 : 32'hA5A5_0005,
        32'hA5A5_0000, 1, "set5");
    add(0, 1, 5, 5, 5, 32'h2222_2222, BYP ? 32'h2222_2222 : 32'h1111_1111,
        BYP ? 32'h2222_2222 : 32'h1111_1111, 1, "rw5_same_cycle");
    add(0, 0, 5, 5, 0, 32'h0, 32'h2222_2222, 32'h2222_2222, 1, "rd5_after");

    // reset blocks forwarding, and wins over the write at the edge
    add(1, 1, 2, 6, 2, 32'hFFFF_FFFF, 32'hA5A5_0002, 32'hA5A5_0006, 1, "rst_and_we");
    add(0, 0, 2, 6, 0, 32'h0, 32'h0, 32'h0, 1, "after_rst_we");

    foreach (vecs[i]) apply(vecs[i]);

    // random traffic against an array model; model is cleared by the last vector's reset
    foreach (model[i]) model[i] = '0;
    for (int n = 0; n < 400; n++) begin
      v.rst = ($urandom_range(0, 24) == 0);
      v.we  = $urandom_range(0, 1) != 0;
      v.ra1 = AW'($urandom_range(0, DEPTH - 1));
      v.ra2 = ($urandom_range(0, 3) == 0) ? v.ra1 : AW'($urandom_range(0, DEPTH - 1));
      v.wa  = ($urandom_range(0, 2) == 0) ? v.ra1 : AW'($urandom_range(0, DEPTH - 1));
      v.wd  = $urandom;
      v.chk = 1'b1;
      v.name = "random";
      v.e1 = (BYP && v.we && !v.rst && v.ra1 == v.wa) ? v.wd : model[v.ra1];
      v.e2 = (BYP && v.we && !v.rst && v.ra2 == v.wa) ? v.wd : model[v.ra2];
      apply(v);
      if (v.rst) foreach (model[i]) model[i] = '0;
      else if (v.we) model[v.wa] = v.wd;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_reg_file
